nibble_serializer: RTL and testbench

Downstream consumer of the nibble-data stimulus source. It requests a new DATA_W-bit word with a one-cycle `ask_for_data` pulse and latches the word once the source has updated it. It then emits the word MSB-first as a two-wire serial frame on `scl`/`sda`: a START condition, the data bits, an optional parity bit and a STOP condition. It sits between the stimulus generator and the serial-to-parallel receiver under test.

---
 rtl/nibser_pkg.sv | 23 ++
 rtl/nibser_shreg.sv | 44 ++++
 rtl/nibble_serializer.sv | 195 +++++++++++++++++++
 tb/tb_nibble_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibser_pkg.sv
// nibble_serializer shared types and phase lengths.
// Parity option: define NIBSER_PARITY_EN.
package nibser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    BIT,
    PAR,
    STOP,
    GAP
  } state_t;

  localparam int START_CYC = 2;
  localparam int STOP_CYC  = 3;
  localparam int BIT_CYC   = 2;

  // phase counter width; must hold GAP_CYC-1
  localparam int PH_W = 8;

endpackage

// File: rtl/nibser_shreg.sv
// Parallel-load shift-left register with look-ahead MSB and parity.
// Parity option: define NIBSER_PARITY_EN in the top.
module nibser_shreg
  import nibser_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              msb_nxt,
  output logic              par
);

  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] q_nxt;

  always_comb begin
    q_nxt = q;
    if (load) begin
      q_nxt = d;
    end else if (shift) begin
      q_nxt = q << 1;
    end
  end

  // MSB of the value q takes at the coming edge, so sda can be registered
  assign msb_nxt = q_nxt[DATA_W-1];

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      par <= 1'b0;
    end else begin
      q <= q_nxt;
      if (load) begin
        par <= ^d;
      end
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// Requests a word, then sends it MSB-first as a START/bits/STOP frame.
// Parity option: define NIBSER_PARITY_EN to add a PAR phase.
module nibble_serializer
  import nibser_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic              ask_for_data,
  output logic              scl,
  output logic              sda,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t          state;
  state_t          nxt_state;
  logic [PH_W-1:0] cnt;
  logic [PH_W-1:0] nxt_cnt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   nxt_idx;

  logic load;
  logic shift;
  logic done;
  logic msb_nxt;
  logic par;

  logic o_ask;
  logic o_scl;
  logic o_sda;
  logic o_busy;

  nibser_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .sclk    (sclk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .d       (data),
    .msb_nxt (msb_nxt),
    .par     (par)
  );

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + PH_W'(1);
    nxt_idx   = idx;
    load      = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (en) begin
          nxt_state = REQ;
        end
      end
      REQ: begin
        nxt_cnt   = '0;
        nxt_state = WAIT;
      end
      WAIT: begin
        nxt_cnt   = '0;
        nxt_state = START;
        load      = 1'b1;
      end
      START: begin
        if (cnt == PH_W'(START_CYC - 1)) begin
          nxt_cnt   = '0;
          nxt_state = BIT;
          nxt_idx   = IW'(DATA_W - 1);
        end
      end
      BIT: begin
        if (cnt == PH_W'(BIT_CYC - 1)) begin
          nxt_cnt = '0;
          shift   = 1'b1;
          if (idx == '0) begin
`ifdef NIBSER_PARITY_EN
            nxt_state = PAR;
`else
            nxt_state = STOP;
`endif
          end else begin
            nxt_idx = idx - IW'(1);
          end
        end
      end
      PAR: begin
        if (cnt == PH_W'(BIT_CYC - 1)) begin
          nxt_cnt   = '0;
          nxt_state = STOP;
        end
      end
      STOP: begin
        if (cnt == PH_W'(STOP_CYC - 1)) begin
          nxt_cnt   = '0;
          nxt_state = GAP;
          done      = 1'b1;
        end
      end
      GAP: begin
        if (cnt == PH_W'(GAP_CYC - 1)) begin
          nxt_cnt   = '0;
          nxt_state = en ? REQ : IDLE;
        end
      end
      default: begin
        nxt_cnt   = '0;
        nxt_state = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the state being entered, then registered
  always_comb begin
    o_ask  = 1'b0;
    o_busy = 1'b1;
    o_scl  = 1'b1;
    o_sda  = 1'b1;
    unique case (nxt_state)
      IDLE: begin
        o_busy = 1'b0;
      end
      REQ: begin
        o_ask = 1'b1;
      end
      WAIT: begin
        o_ask = 1'b0;
      end
      START: begin
        o_scl = (nxt_cnt == '0);
        o_sda = 1'b0;
      end
      BIT: begin
        o_scl = nxt_cnt[0];
        o_sda = msb_nxt;
      end
      PAR: begin
        o_scl = nxt_cnt[0];
        o_sda = par;
      end
      STOP: begin
        o_scl = (nxt_cnt != '0);
        o_sda = (nxt_cnt == PH_W'(STOP_CYC - 1));
      end
      GAP: begin
        o_busy = 1'b0;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      idx   <= nxt_idx;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      ask_for_data <= 1'b0;
      scl          <= 1'b1;
      sda          <= 1'b1;
      busy         <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      ask_for_data <= o_ask;
      scl          <= o_scl;
      sda          <= o_sda;
      busy         <= o_busy;
      if (done) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer (default and NIBSER_PARITY_EN builds).
// Incrementing source model plus a CNT_W=2 instance for counter wrap.
module tb_nibble_serializer;

`ifdef NIBSER_PARITY_EN
  localparam int FLEN = 17;
  localparam int NB   = 5;
`else
  localparam int FLEN = 15;
  localparam int NB   = 4;
`endif
  localparam int PER = FLEN + 2;

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic       en   = 1'b0;
  logic [3:0] src  = 4'd0;
  logic       ask;
  logic       scl;
  logic       sda;
  logic       busy;
  logic [7:0] fc;

  logic       en2 = 1'b0;
  logic [3:0] d2  = 4'ha;
  logic       ask2;
  logic       scl2;
  logic       sda2;
  logic       busy2;
  logic [1:0] fc2;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  nibble_serializer #(
    .DATA_W (4),
    .GAP_CYC(2),
    .CNT_W  (8)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .en          (en),
    .data        (src),
    .ask_for_data(ask),
    .scl         (scl),
    .sda         (sda),
    .busy        (busy),
    .frame_cnt   (fc)
  );

  nibble_serializer #(
    .DATA_W (4),
    .GAP_CYC(2),
    .CNT_W  (2)
  ) u_w (
    .sclk        (sclk),
    .rst         (rst),
    .en          (en2),
    .data        (d2),
    .ask_for_data(ask2),
    .scl         (scl2),
    .sda         (sda2),
    .busy        (busy2),
    .frame_cnt   (fc2)
  );

  always #5 sclk = ~sclk;

  // source: advances its word on each request
  always @(posedge sclk) begin
    cyc <= cyc + 1;
    if (ask) src <= src + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic       s_scl [0:FLEN];
  logic       s_sda [0:FLEN];
  logic       s_bz  [0:FLEN];
  logic [4:0] bits;
  logic [3:0] wrd;
  int         nrise;
  int         t_req;
  logic [7:0] fc_end;
  logic       got;
  logic       st_ok;
  logic       sp_ok;
  logic       chg_ok;
  logic       bz_ok;

  task automatic capture(input int drop_at);
    int k;
    k = 0;
    while (ask !== 1'b1 && k < 60) begin
      @(negedge sclk);
      k++;
    end
    got   = (ask === 1'b1);
    t_req = cyc;
    for (int i = 0; i <= FLEN; i++) begin
      if (i > 0) @(negedge sclk);
      if (i == drop_at) en = 1'b0;
      s_scl[i] = scl;
      s_sda[i] = sda;
      s_bz[i]  = busy;
    end
    fc_end = fc;
    bits   = '0;
    nrise  = 0;
    for (int i = 3; i <= FLEN - 3; i++) begin
      if (s_scl[i-1] == 1'b0 && s_scl[i] == 1'b1) begin
        bits = {bits[3:0], s_sda[i]};
        nrise++;
      end
    end
`ifdef NIBSER_PARITY_EN
    wrd = bits[4:1];
`else
    wrd = bits[3:0];
`endif
    st_ok = s_scl[1] && s_sda[1] && s_scl[2] && !s_sda[2];
    sp_ok = s_scl[FLEN-2] && !s_sda[FLEN-2] &&
            s_scl[FLEN-1] && s_sda[FLEN-1];
    chg_ok = 1'b1;
    for (int i = 3; i <= FLEN - 2; i++) begin
      if (s_sda[i] != s_sda[i-1] && s_scl[i]) chg_ok = 1'b0;
    end
    bz_ok = s_bz[0] && s_bz[FLEN-1] && !s_bz[FLEN];
  endtask

  task automatic frame_checks(input string tag, input logic [3:0] w,
                              input logic [7:0] f);
    check({tag, "_req"}, 32'(got), 32'd1);
    check({tag, "_word"}, 32'(wrd), 32'(w));
    check({tag, "_nbits"}, 32'(nrise), 32'(NB));
    check({tag, "_start"}, 32'(st_ok), 32'd1);
    check({tag, "_stop"}, 32'(sp_ok), 32'd1);
    check({tag, "_sda_chg"}, 32'(chg_ok), 32'd1);
    check({tag, "_busy"}, 32'(bz_ok), 32'd1);
    check({tag, "_fcnt"}, 32'(fc_end), 32'(f));
  endtask

  int         t_prev;
  logic       seen;
  logic       idle_ok;
  int         k;
  logic [1:0] prev2;
  logic [1:0] wrap_exp [0:4];

  initial begin
    wrap_exp[0] = 2'd1;
    wrap_exp[1] = 2'd2;
    wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0;
    wrap_exp[4] = 2'd1;

    rst = 1'b1;
    repeat (3) @(negedge sclk);
    check("rst_ask", 32'(ask), 32'd0);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fcnt", 32'(fc), 32'd0);
    rst = 1'b0;
    @(negedge sclk);
    check("idle_ask", 32'(ask), 32'd0);
    en = 1'b1;

    // first frame carries 0001; back-to-back frames 2 and 3
    capture(-1);
    frame_checks("f1", 4'd1, 8'd1);
`ifdef NIBSER_PARITY_EN
    check("f1_par", 32'(bits[0]), 32'd1);
`endif
    t_prev = t_req;
    capture(-1);
    frame_checks("f2", 4'd2, 8'd2);
    check("f2_period", 32'(t_req - t_prev), 32'(PER));
`ifdef NIBSER_PARITY_EN
    check("f2_par", 32'(bits[0]), 32'd1);
`endif
    t_prev = t_req;
    capture(-1);
    frame_checks("f3", 4'd3, 8'd3);
    check("f3_period", 32'(t_req - t_prev), 32'(PER));
`ifdef NIBSER_PARITY_EN
    check("f3_par", 32'(bits[0]), 32'd0);
`endif

    // en dropped mid-BIT: frame completes, then idle
    capture(7);
    frame_checks("f4", 4'd4, 8'd4);
    seen    = 1'b0;
    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge sclk);
      if (ask) seen = 1'b1;
      if (!(scl && sda && !busy)) idle_ok = 1'b0;
    end
    check("drop_no_ask", 32'(seen), 32'd0);
    check("drop_idle", 32'(idle_ok), 32'd1);

    // reset during BIT aborts frame 5 (word 5)
    en = 1'b1;
    k  = 0;
    while (ask !== 1'b1 && k < 10) begin
      @(negedge sclk);
      k++;
    end
    check("f5_req", 32'(ask), 32'd1);
    repeat (6) @(negedge sclk);
    check("f5_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_scl", 32'(scl), 32'd1);
    check("mid_rst_sda", 32'(sda), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_fcnt", 32'(fc), 32'd0);
    @(negedge sclk);
    rst = 1'b0;
    @(negedge sclk);
    check("post_rst_ask", 32'(ask), 32'd1);
    capture(-1);
    frame_checks("f6", 4'd6, 8'd1);
`ifdef NIBSER_PARITY_EN
    check("f6_par", 32'(bits[0]), 32'd0);
`endif
    capture(-1);
    en = 1'b0;
    frame_checks("f7", 4'd7, 8'd2);
`ifdef NIBSER_PARITY_EN
    check("f7_par", 32'(bits[0]), 32'd1);
`endif

    // CNT_W=2 instance: counter wraps silently
    en2   = 1'b1;
    prev2 = fc2;
    for (int j = 0; j < 5; j++) begin
      k = 0;
      while (fc2 === prev2 && k < 40) begin
        @(negedge sclk);
        k++;
      end
      check("wrap_fcnt", 32'(fc2), 32'(wrap_exp[j]));
      prev2 = fc2;
    end
    en2 = 1'b0;

    repeat (4) @(negedge sclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
